// File: rtl/sparc_exu_thrreg_n.sv
// Per-thread architectural register bank: NTHR copies of a SIZE-bit register
// with W-stage write, per-thread +/-1 modify, one-hot read and select checking.
module sparc_exu_thrreg_n #(
  parameter int              SIZE    = 3,
  parameter int              NTHR    = 4,
  parameter logic [SIZE-1:0] RST_VAL = '0,
  parameter bit              SAT     = 1'b0,
  parameter bit              BYPASS  = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            se,
  input  logic [NTHR-1:0] thr_out,
  output logic [SIZE-1:0] data_out,
  input  logic            wen_w,
  input  logic [NTHR-1:0] thr_w,
  input  logic [SIZE-1:0] data_in_w,
  input  logic            mod_en,
  input  logic [NTHR-1:0] mod_thr,
  input  logic            mod_dec,
  output logic            lim_hit,
  output logic            sel_err
);

  localparam logic [SIZE-1:0] ALL_ONES = {SIZE{1'b1}};
  localparam logic [SIZE-1:0] ONE      = SIZE'(1);

  // Scan enable only matters to the physical scan flops.
  logic unused_se;
  assign unused_se = se;

  logic [SIZE-1:0] val_q   [NTHR];
  logic [SIZE-1:0] val_d   [NTHR];
  logic [SIZE-1:0] mod_val [NTHR];
  logic [NTHR-1:0] wr_sel;
  logic [NTHR-1:0] md_sel;
  logic [NTHR-1:0] at_lim;
  logic            lim_d;
  logic            sel_err_d;
  logic [SIZE-1:0] rd_val;
  logic            byp_hit;

  // True when more than one bit of the select is set.
  function automatic logic multi_hot(input logic [NTHR-1:0] v);
    return |(v & (v - NTHR'(1)));
  endfunction

  assign wr_sel = {NTHR{wen_w}} & thr_w;
  // A same-thread write wins, so the modify is not effective there.
  assign md_sel = {NTHR{mod_en}} & mod_thr & ~wr_sel;

  always_comb begin
    for (int t = 0; t < NTHR; t++) begin
      at_lim[t]  = mod_dec ? (val_q[t] == '0) : (val_q[t] == ALL_ONES);
      mod_val[t] = mod_dec ? (val_q[t] - ONE) : (val_q[t] + ONE);
      if (SAT && at_lim[t]) begin
        mod_val[t] = val_q[t];
      end
    end
  end

  always_comb begin
    for (int t = 0; t < NTHR; t++) begin
      val_d[t] = val_q[t];
      if (wr_sel[t]) begin
        val_d[t] = data_in_w;
      end else if (md_sel[t]) begin
        val_d[t] = mod_val[t];
      end
    end
  end

  assign lim_d = |(md_sel & at_lim);

  assign sel_err_d = sel_err
                   | (wen_w  & multi_hot(thr_w))
                   | (mod_en & multi_hot(mod_thr))
                   | multi_hot(thr_out);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int t = 0; t < NTHR; t++) begin
        val_q[t] <= RST_VAL;
      end
      lim_hit <= 1'b0;
      sel_err <= 1'b0;
    end else begin
      for (int t = 0; t < NTHR; t++) begin
        val_q[t] <= val_d[t];
      end
      lim_hit <= lim_d;
      sel_err <= sel_err_d;
    end
  end

  // AND-OR read so unused or multi-hot select patterns never produce X.
  always_comb begin
    rd_val = '0;
    for (int t = 0; t < NTHR; t++) begin
      rd_val = rd_val | ({SIZE{thr_out[t]}} & val_q[t]);
    end
  end

  assign byp_hit  = BYPASS & wen_w & (|(thr_w & thr_out));
  assign data_out = byp_hit ? data_in_w : rd_val;

endmodule

// File: tb/tb_sparc_exu_thrreg_n.sv
// Bench for sparc_exu_thrreg_n: a modulo/bypass instance and a saturating/no-bypass
// instance share one stimulus stream and are compared against a per-thread array model.
module tb_sparc_exu_thrreg_n;
  localparam int SIZE = 3;
  localparam int NTHR = 4;
  localparam int MAXV = 7;

  logic            clk = 1'b0;
  logic            reset;
  logic            se;
  logic [NTHR-1:0] thr_out;
  logic            wen_w;
  logic [NTHR-1:0] thr_w;
  logic [SIZE-1:0] data_in_w;
  logic            mod_en;
  logic [NTHR-1:0] mod_thr;
  logic            mod_dec;
  logic [SIZE-1:0] dout_a, dout_b;
  logic            lim_a, lim_b, err_a, err_b;

  int n_cmp = 0;
  int n_err = 0;

  // Model: index 0 = modulo/bypass/RST 5, index 1 = saturating/no bypass/RST 0.
  int mem   [2][NTHR];
  int lim_m [2];
  int err_m [2];

  sparc_exu_thrreg_n #(.SIZE(SIZE), .NTHR(NTHR), .RST_VAL(3'd5), .SAT(1'b0), .BYPASS(1'b1)) u_a (
    .clk(clk), .reset(reset), .se(se), .thr_out(thr_out), .data_out(dout_a),
    .wen_w(wen_w), .thr_w(thr_w), .data_in_w(data_in_w), .mod_en(mod_en),
    .mod_thr(mod_thr), .mod_dec(mod_dec), .lim_hit(lim_a), .sel_err(err_a));

  sparc_exu_thrreg_n #(.SIZE(SIZE), .NTHR(NTHR), .RST_VAL(3'd0), .SAT(1'b1), .BYPASS(1'b0)) u_b (
    .clk(clk), .reset(reset), .se(se), .thr_out(thr_out), .data_out(dout_b),
    .wen_w(wen_w), .thr_w(thr_w), .data_in_w(data_in_w), .mod_en(mod_en),
    .mod_thr(mod_thr), .mod_dec(mod_dec), .lim_hit(lim_b), .sel_err(err_b));

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int rst_of(input int i);
    return (i == 0) ? 5 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int t = 0; t < NTHR; t++) mem[i][t] = rst_of(i);
      lim_m[i] = 0;
      err_m[i] = 0;
    end
  endtask

  function automatic int model_read(input int i);
    int r = 0;
    for (int t = 0; t < NTHR; t++) if (thr_out[t]) r = r | mem[i][t];
    if (i == 0 && wen_w && ((thr_w & thr_out) != 0)) r = int'(data_in_w);
    return r;
  endfunction

  // Computes the post-edge model from the inputs held across the edge, then waits for it.
  task automatic tick();
    int nxt [2][NTHR];
    int l   [2];
    for (int i = 0; i < 2; i++) begin
      l[i] = 0;
      for (int t = 0; t < NTHR; t++) begin
        int v = mem[i][t];
        if (wen_w && thr_w[t]) begin
          v = int'(data_in_w);
        end else if (mod_en && mod_thr[t]) begin
          if (mod_dec) begin
            if (v == 0) begin l[i] = 1; v = (i == 1) ? 0 : MAXV; end
            else v = v - 1;
          end else begin
            if (v == MAXV) begin l[i] = 1; v = (i == 1) ? MAXV : 0; end
            else v = v + 1;
          end
        end
        nxt[i][t] = v;
      end
      if ((wen_w && $countones(thr_w) > 1) || (mod_en && $countones(mod_thr) > 1) ||
          $countones(thr_out) > 1) err_m[i] = 1;
    end
    @(posedge clk);
    #1;
    if (reset) begin
      model_reset();
    end else begin
      mem   = nxt;
      lim_m = l;
    end
  endtask

  task automatic idle();
    wen_w = 1'b0; thr_w = '0; data_in_w = '0;
    mod_en = 1'b0; mod_thr = '0; mod_dec = 1'b0;
  endtask

  task automatic check_read(input string tag);
    check({tag, "_rd_a"}, 32'(dout_a), 32'(model_read(0)));
    check({tag, "_rd_b"}, 32'(dout_b), 32'(model_read(1)));
  endtask

  // Flags plus a one-hot read sweep of every thread; fits inside half a clock period.
  task automatic check_state(input string tag);
    logic [NTHR-1:0] saved = thr_out;
    check({tag, "_lim_a"}, 32'(lim_a), 32'(lim_m[0]));
    check({tag, "_lim_b"}, 32'(lim_b), 32'(lim_m[1]));
    check({tag, "_err_a"}, 32'(err_a), 32'(err_m[0]));
    check({tag, "_err_b"}, 32'(err_b), 32'(err_m[1]));
    for (int t = 0; t < NTHR; t++) begin
      thr_out = NTHR'(1) << t;
      #1;
      check_read($sformatf("%s_t%0d", tag, t));
    end
    thr_out = saved;
    #1;
  endtask

  task automatic write(input int t, input int v);
    idle();
    wen_w = 1'b1; thr_w = NTHR'(1) << t; data_in_w = SIZE'(v);
    tick();
    idle();
  endtask

  task automatic modify(input int t, input logic dec);
    idle();
    mod_en = 1'b1; mod_thr = NTHR'(1) << t; mod_dec = dec;
    tick();
    idle();
  endtask

  initial begin
    se = 1'b0; thr_out = '0; idle();
    reset = 1'b1;
    model_reset();
    #23;
    reset = 1'b0;
    @(posedge clk); #1;
    check_state("reset");

    // Same-cycle write bypass on instance a only.
    wen_w = 1'b1; thr_w = 4'b0010; data_in_w = 3'd3; thr_out = 4'b0010;
    #1;
    check("byp_a", 32'(dout_a), 32'd3);
    check("nobyp_b", 32'(dout_b), 32'd0);
    tick();
    idle();
    #1;
    check("wr_a", 32'(dout_a), 32'd3);
    check("wr_b", 32'(dout_b), 32'd3);
    check_state("write");

    // Increment wrap / clamp, then decrement.
    write(0, 7);
    modify(0, 1'b0);
    thr_out = 4'b0001; #1;
    check("wrap_inc_a", 32'(dout_a), 32'd0);
    check("sat_inc_b", 32'(dout_b), 32'd7);
    check("wrap_lim_a", 32'(lim_a), 32'd1);
    check("sat_lim_b", 32'(lim_b), 32'd1);
    tick();
    check("lim_clr_a", 32'(lim_a), 32'd0);
    check("lim_clr_b", 32'(lim_b), 32'd0);
    modify(0, 1'b1);
    #1;
    check("wrap_dec_a", 32'(dout_a), 32'd7);
    check("dec_b", 32'(dout_b), 32'd6);
    check("wrap_dec_lim_a", 32'(lim_a), 32'd1);
    check("dec_lim_b", 32'(lim_b), 32'd0);
    check_state("wrap");

    // Saturation around thread 2.
    write(2, 0);
    modify(2, 1'b1);
    thr_out = 4'b0100; #1;
    check("sat_dec_b", 32'(dout_b), 32'd0);
    check("sat_dec_lim_b", 32'(lim_b), 32'd1);
    write(2, 6);
    modify(2, 1'b0);
    #1;
    check("sat_inc1_b", 32'(dout_b), 32'd7);
    check("sat_inc1_lim_b", 32'(lim_b), 32'd0);
    modify(2, 1'b0);
    #1;
    check("sat_inc2_b", 32'(dout_b), 32'd7);
    check("sat_inc2_lim_b", 32'(lim_b), 32'd1);
    check_state("sat");

    // Write beats modify on the same thread; different threads both apply.
    write(3, 7);
    wen_w = 1'b1; thr_w = 4'b1000; data_in_w = 3'd4;
    mod_en = 1'b1; mod_thr = 4'b1000; mod_dec = 1'b0;
    tick();
    idle();
    thr_out = 4'b1000; #1;
    check("coll_a", 32'(dout_a), 32'd4);
    check("coll_lim_a", 32'(lim_a), 32'd0);
    check("coll_lim_b", 32'(lim_b), 32'd0);
    write(3, 7);
    wen_w = 1'b1; thr_w = 4'b0001; data_in_w = 3'd4;
    mod_en = 1'b1; mod_thr = 4'b1000; mod_dec = 1'b0;
    tick();
    idle();
    check("split_lim_a", 32'(lim_a), 32'd1);
    check_state("split");

    // Unqualified multi-hot selects are ignored; multi-hot read ORs and is sticky.
    thr_w = 4'b0011; mod_thr = 4'b0110; thr_out = 4'b0001;
    tick();
    idle();
    check("unq_err_a", 32'(err_a), 32'd0);
    check("unq_err_b", 32'(err_b), 32'd0);
    thr_out = 4'b0101; #1;
    check("or_rd_a", 32'(dout_a), 32'(mem[0][0] | mem[0][2]));
    check_read("multi");
    tick();
    thr_out = 4'b0001;
    for (int k = 0; k < 3; k++) tick();
    check("sticky_err_a", 32'(err_a), 32'd1);
    check("sticky_err_b", 32'(err_b), 32'd1);

    // Randomized mixed traffic, mostly one-hot selects.
    for (int n = 0; n < 400; n++) begin
      wen_w     = ($urandom_range(0, 2) == 0);
      thr_w     = ($urandom_range(0, 15) == 0) ? NTHR'($urandom) : NTHR'(1) << $urandom_range(0, NTHR - 1);
      data_in_w = SIZE'($urandom);
      mod_en    = ($urandom_range(0, 1) == 0);
      mod_thr   = ($urandom_range(0, 15) == 0) ? NTHR'($urandom) : NTHR'(1) << $urandom_range(0, NTHR - 1);
      mod_dec   = 1'($urandom);
      thr_out   = ($urandom_range(0, 15) == 0) ? NTHR'($urandom) : NTHR'(1) << $urandom_range(0, NTHR - 1);
      #1;
      check_read("rnd");
      tick();
      check("rnd_lim_a", 32'(lim_a), 32'(lim_m[0]));
      check("rnd_lim_b", 32'(lim_b), 32'(lim_m[1]));
      check("rnd_err_a", 32'(err_a), 32'(err_m[0]));
      check("rnd_err_b", 32'(err_b), 32'(err_m[1]));
    end
    idle();
    thr_out = 4'b0001;
    tick();
    check_state("rnd_end");

    // Asynchronous reset mid-cycle with flags set and a modify in flight.
    write(0, 7);
    mod_en = 1'b1; mod_thr = 4'b0001; mod_dec = 1'b0; thr_out = 4'b0011;
    tick();
    check("pre_rst_lim_a", 32'(lim_a), 32'd1);
    check("pre_rst_err_a", 32'(err_a), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    thr_out = 4'b0001;
    check_state("async_rst");
    check("rst_lim_a", 32'(lim_a), 32'd0);
    tick();
    #2;
    reset = 1'b0;
    idle();
    tick();
    check_state("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
